// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions for the TX path and a future RX FIFO.
//   UART_DATA_WIDTH : default character width.
//   UART_FIFO_CNT_W : occupancy field width in fifo_status_t, wide enough for any
//                     FIFO depth in use.
//   fifo_status_t   : occupancy and flags of a FIFO, in a common layout.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned UART_FIFO_CNT_W = 16;

    typedef struct packed {
        logic [UART_FIFO_CNT_W-1:0] count;
        logic                       empty;
        logic                       full;
        logic                       almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_mem
//   Storage for uart_tx_fifo. It is a DEPTH x DATA_WIDTH register array with one
//   write port and one asynchronous read port. The storage resets to zero, so
//   the read port never returns X.
// Ports
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset, clears every entry
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  combinational read data, mem[i_raddr]
// -----------------------------------------------------------------------------
module uart_tx_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit byte FIFO that sits upstream of the uart_tx serializer. The host
//   writes bytes with a valid/ready handshake. The FIFO presents the head entry
//   on tx_data/tx_valid. The head is popped on a 0->1 edge of the serializer's
//   tx_active output, which marks the start of a frame.
//   Optional build macro: UART_TX_FIFO_FLUSH_EN adds the flush input. A flush
//   discards all queued bytes on the next edge and overrides any push or pop in
//   that cycle. The storage contents are kept.
// Ports
//   uart_clk      rising-edge clock
//   rst           asynchronous active-high reset
//   wr_data       byte to enqueue
//   wr_valid      write request
//   wr_ready      FIFO can accept (= !full)
//   tx_data       head entry, to uart_tx
//   tx_valid      head valid (= !empty), to uart_tx
//   tx_active     from uart_tx; a rising edge consumes the head
//   count         occupancy 0..DEPTH
//   empty         count == 0
//   full          count == DEPTH
//   almost_empty  count <= AEMPTY_THRESH
//   flush         (UART_TX_FIFO_FLUSH_EN only) drop all queued bytes
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = UART_DATA_WIDTH,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                     uart_clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_active,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty
`ifdef UART_TX_FIFO_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // The pointers carry one extra wrap bit, so full and empty can be told apart.
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_count;
    logic          r_tx_active_q;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A flush wins over both ports, so the write is not stored either.
    assign w_push = wr_valid & ~w_full & ~w_flush;
    // A frame start only consumes the head if there is one. A rise while empty is ignored.
    assign w_pop  = tx_active & ~r_tx_active_q & ~w_empty & ~w_flush;

    // r_tx_active_q resets high. A tx_active already high at reset release
    // then does not look like a new frame.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_tx_active_q <= 1'b1;
        end else begin
            r_tx_active_q <= tx_active;
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + PW'(w_push);
                r_rd_ptr <= r_rd_ptr + PW'(w_pop);
                r_count  <= r_count + PW'(w_push) - PW'(w_pop);
            end
        end
    end

    uart_tx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (uart_clk),
        .i_rst   (rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (tx_data)
    );

    assign wr_ready     = ~w_full;
    assign tx_valid     = ~w_empty;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (32'(r_count) <= AEMPTY_THRESH);

endmodule
